// File: rtl/dmem_resp_pkg.sv
// Shared types, widths and the address-check helper for the data-memory responder.
package dmem_resp_pkg;

  localparam int unsigned LAT_W  = 4;
  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  // True for a misaligned address or one that falls beyond the word array.
  function automatic logic addr_err(input logic [ADDR_W-1:0] addr,
                                    input int unsigned       depth_log2);
    logic [ADDR_W-1:0] hi_mask;
    hi_mask = ~((ADDR_W'(1) << (depth_log2 + 2)) - ADDR_W'(1));
    return (addr[1:0] != 2'b00) || ((addr & hi_mask) != '0);
  endfunction

endpackage

// File: rtl/dmem_responder_if.sv
// Request/response bus between the CPU MEM stage and the data-memory responder.
interface dmem_responder_if;
  import dmem_resp_pkg::*;

  logic              req_i;
  logic              we_i;
  logic [ADDR_W-1:0] addr_i;
  logic [DATA_W-1:0] wdata_i;
  logic              stall_o;
  logic              ack_o;
  logic [DATA_W-1:0] rdata_o;
  logic              err_o;

  modport master (
    output req_i, we_i, addr_i, wdata_i,
    input  stall_o, ack_o, rdata_o, err_o
  );

  modport slave (
    input  req_i, we_i, addr_i, wdata_i,
    output stall_o, ack_o, rdata_o, err_o
  );

endinterface

// File: rtl/dmem_array.sv
// Word storage: synchronous write, asynchronous read, deliberately not reset.
module dmem_array
  import dmem_resp_pkg::*;
#(
  parameter int unsigned DEPTH_LOG2 = 10
) (
  input  logic                  clk_i,
  input  logic                  i_we,
  input  logic [DEPTH_LOG2-1:0] i_waddr,
  input  logic [DATA_W-1:0]     i_wdata,
  input  logic [DEPTH_LOG2-1:0] i_raddr,
  output logic [DATA_W-1:0]     o_rdata
);

  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;

  logic [DATA_W-1:0] r_mem [DEPTH];

  // Commit a store word on the clock edge.
  always_ff @(posedge clk_i) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/dmem_responder.sv
// Multi-cycle data-memory responder: one access in flight, fixed latency, single ack pulse.
module dmem_responder
  import dmem_resp_pkg::*;
#(
  parameter int unsigned DEPTH_LOG2 = 10,
  parameter int unsigned LATENCY    = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  dmem_responder_if.slave  bus
);

  state_e                r_state;
  logic [LAT_W-1:0]      r_cnt;
  logic                  r_we;
  logic [ADDR_W-1:0]     r_addr;
  logic [DATA_W-1:0]     r_wdata;
  logic                  r_ack;
  logic                  r_err;
  logic [DATA_W-1:0]     r_rdata;

  logic                  w_err;
  logic                  w_done;
  logic                  w_mem_we;
  logic [DEPTH_LOG2-1:0] w_idx;
  logic [DATA_W-1:0]     w_mem_rdata;

  assign w_err    = addr_err(r_addr, DEPTH_LOG2);
  assign w_idx    = r_addr[DEPTH_LOG2+1:2];
  // Last BUSY cycle: the coming edge completes the access.
  assign w_done   = (r_state == ST_BUSY) && (r_cnt == LAT_W'(1));
  assign w_mem_we = w_done && r_we && !w_err;

  dmem_array #(
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_array (
    .clk_i   (clk_i),
    .i_we    (w_mem_we),
    .i_waddr (w_idx),
    .i_wdata (r_wdata),
    .i_raddr (w_idx),
    .o_rdata (w_mem_rdata)
  );

  // FSM, latency counter, request capture and registered response.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_ack   <= 1'b0;
      r_err   <= 1'b0;
      r_rdata <= '0;
    end else begin
      r_ack <= 1'b0;
      r_err <= 1'b0;
      case (r_state)
        ST_IDLE, ST_RESP: begin
          if (bus.req_i) begin
            r_we    <= bus.we_i;
            r_addr  <= bus.addr_i;
            r_wdata <= bus.wdata_i;
            r_cnt   <= LAT_W'(LATENCY);
            r_state <= ST_BUSY;
          end else begin
            r_state <= ST_IDLE;
          end
        end
        ST_BUSY: begin
          r_cnt <= r_cnt - LAT_W'(1);
          if (w_done) begin
            r_state <= ST_RESP;
            r_ack   <= 1'b1;
            r_err   <= w_err;
            if (w_err) begin
              r_rdata <= '0;
            end else if (!r_we) begin
              r_rdata <= w_mem_rdata;
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign bus.stall_o = (r_state == ST_BUSY);
  assign bus.ack_o   = r_ack;
  assign bus.err_o   = r_err;
  assign bus.rdata_o = r_rdata;

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: three instances (LATENCY 4, 1, 15) against a word-level reference model.
module tb_dmem_responder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req [3];
  logic        we;
  logic [31:0] addr;
  logic [31:0] wdata;

  logic        stall [3];
  logic        ack   [3];
  logic        err   [3];
  logic [31:0] rdata [3];

  int unsigned lat [3] = '{4, 1, 15};

  // Reference model: per-instance word contents and last response data.
  logic [31:0] mdl_mem   [3][1024];
  bit          mdl_known [3][1024];
  logic [31:0] mdl_rd    [3];
  bit          mdl_rd_ok [3];

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  dmem_responder_if if0 ();
  dmem_responder_if if1 ();
  dmem_responder_if if2 ();

  assign if0.req_i = req[0];
  assign if1.req_i = req[1];
  assign if2.req_i = req[2];
  assign if0.we_i = we;    assign if1.we_i = we;    assign if2.we_i = we;
  assign if0.addr_i = addr;  assign if1.addr_i = addr;  assign if2.addr_i = addr;
  assign if0.wdata_i = wdata; assign if1.wdata_i = wdata; assign if2.wdata_i = wdata;

  assign stall[0] = if0.stall_o; assign ack[0] = if0.ack_o; assign err[0] = if0.err_o; assign rdata[0] = if0.rdata_o;
  assign stall[1] = if1.stall_o; assign ack[1] = if1.ack_o; assign err[1] = if1.err_o; assign rdata[1] = if1.rdata_o;
  assign stall[2] = if2.stall_o; assign ack[2] = if2.ack_o; assign err[2] = if2.err_o; assign rdata[2] = if2.rdata_o;

  dmem_responder #(.DEPTH_LOG2(10), .LATENCY(4))  u_dut0 (.clk_i(clk), .rst_i(rst_n), .bus(if0));
  dmem_responder #(.DEPTH_LOG2(10), .LATENCY(1))  u_dut1 (.clk_i(clk), .rst_i(rst_n), .bus(if1));
  dmem_responder #(.DEPTH_LOG2(10), .LATENCY(15)) u_dut2 (.clk_i(clk), .rst_i(rst_n), .bus(if2));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Idle cycles: nobody stalls or acks.
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      for (int k = 0; k < 3; k++) begin
        chk($sformatf("idle_stall[%0d]", k), 32'(stall[k]), 32'd0);
        chk($sformatf("idle_ack[%0d]", k), 32'(ack[k]), 32'd0);
        chk($sformatf("idle_err[%0d]", k), 32'(err[k]), 32'd0);
      end
    end
  endtask

  // One access on instance k; called at the negedge of its request cycle, returns at the negedge of its ack cycle.
  task automatic txn(input int k, input bit w, input logic [31:0] a, input logic [31:0] d);
    bit          e;
    int unsigned idx;
    int unsigned l;
    l   = lat[k];
    e   = (a % 4 != 0) || (a >= 32'h1000);
    idx = a / 4;
    chk($sformatf("pre_stall[%0d] a=%08h", k, a), 32'(stall[k]), 32'd0);
    req[k] = 1'b1; we = w; addr = a; wdata = d;
    for (int c = 1; c <= int'(l); c++) begin
      @(negedge clk);
      chk($sformatf("busy_stall[%0d] c=%0d", k, c), 32'(stall[k]), 32'd1);
      chk($sformatf("busy_ack[%0d] c=%0d", k, c), 32'(ack[k]), 32'd0);
      req[k] = 1'($urandom); we = 1'($urandom); addr = $urandom; wdata = $urandom;
    end
    @(negedge clk);
    req[k] = 1'b0;
    if (e) begin
      mdl_rd[k] = 32'd0; mdl_rd_ok[k] = 1'b1;
    end else if (w) begin
      mdl_mem[k][idx] = d; mdl_known[k][idx] = 1'b1;
    end else begin
      mdl_rd[k] = mdl_mem[k][idx]; mdl_rd_ok[k] = mdl_known[k][idx];
    end
    chk($sformatf("resp_ack[%0d] a=%08h", k, a), 32'(ack[k]), 32'd1);
    chk($sformatf("resp_stall[%0d] a=%08h", k, a), 32'(stall[k]), 32'd0);
    chk($sformatf("resp_err[%0d] a=%08h", k, a), 32'(err[k]), 32'(e));
    if (mdl_rd_ok[k]) chk($sformatf("resp_rdata[%0d] a=%08h we=%0d", k, a, w), rdata[k], mdl_rd[k]);
  endtask

  initial begin
    bit          w;
    logic [31:0] a;
    int          sel;
    int          k;
    int          gap;

    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      req[i] = 1'b0; mdl_rd[i] = 32'd0; mdl_rd_ok[i] = 1'b1;
      for (int j = 0; j < 1024; j++) mdl_known[i][j] = 1'b0;
    end
    we = 1'b0; addr = 32'd0; wdata = 32'd0;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("rst_stall[%0d]", i), 32'(stall[i]), 32'd0);
      chk($sformatf("rst_ack[%0d]", i), 32'(ack[i]), 32'd0);
      chk($sformatf("rst_err[%0d]", i), 32'(err[i]), 32'd0);
      chk($sformatf("rst_rdata[%0d]", i), rdata[i], 32'd0);
    end
    rst_n = 1'b1;
    idle(2);

    // Directed sequence on the LATENCY=4 instance.
    txn(0, 1'b1, 32'h0, 32'hCAFEF00D);      idle(1);
    txn(0, 1'b1, 32'h8, 32'h01234567);      idle(1);
    txn(0, 1'b1, 32'h10, 32'hDEADBEEF);     idle(1);
    txn(0, 1'b0, 32'h10, 32'h0);            idle(1);
    txn(0, 1'b0, 32'h13, 32'h0);            idle(1);
    txn(0, 1'b1, 32'h1000, 32'hBAD0BAD0);   idle(1);
    txn(0, 1'b0, 32'h0, 32'h0);             idle(1);
    txn(0, 1'b1, 32'h4, 32'h11111111);
    txn(0, 1'b0, 32'h4, 32'h0);             idle(1);

    // Store cut short by reset in its second BUSY cycle.
    req[0] = 1'b1; we = 1'b1; addr = 32'h8; wdata = 32'h5A5A5A5A;
    @(negedge clk);
    req[0] = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("midrst_stall[%0d]", i), 32'(stall[i]), 32'd0);
      chk($sformatf("midrst_ack[%0d]", i), 32'(ack[i]), 32'd0);
      chk($sformatf("midrst_rdata[%0d]", i), rdata[i], 32'd0);
      mdl_rd[i] = 32'd0; mdl_rd_ok[i] = 1'b1;
    end
    @(negedge clk);
    rst_n = 1'b1;
    idle(2);
    txn(0, 1'b0, 32'h8, 32'h0);             idle(1);

    // Latency extremes.
    for (int i = 1; i < 3; i++) begin
      txn(i, 1'b1, 32'h20, 32'hA5A50000 + 32'(i)); idle(1);
      txn(i, 1'b0, 32'h20, 32'h0);                 idle(1);
      txn(i, 1'b1, 32'h24, 32'h0BADCAFE);
      txn(i, 1'b0, 32'h24, 32'h0);
      txn(i, 1'b0, 32'h22, 32'h0);                 idle(1);
    end

    // Randomized mix across all three instances.
    for (int n = 0; n < 60; n++) begin
      k   = $urandom_range(0, 2);
      sel = $urandom_range(0, 9);
      w   = 1'($urandom);
      if (sel == 0) begin
        a = ($urandom_range(0, 31) * 4) + $urandom_range(1, 3);
      end else if (sel == 1) begin
        a = $urandom;
        if (a < 32'h1000) a = a | 32'h1000;
      end else begin
        a = $urandom_range(0, 31) * 4;
      end
      txn(k, w, a, $urandom);
      gap = $urandom_range(0, 2);
      if (gap != 0) idle(gap);
    end
    idle(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
